// File: rtl/bm_dag2_demod.sv
// Keyed-XOR symbol demodulator with parity check and an output FIFO.
//
// A sync symbol loads the descrambling key and locks the block. While locked,
// each data symbol is unmasked with the current key, checked against its
// even-parity bit, queued as {data, err}, and the key steps by one. Three
// parity errors in a row drop lock until the next sync symbol arrives.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   in_valid/in_ready     input handshake for sym_in/par_in/sync_in
//   sym_in                masked symbol, or the new key when sync_in=1
//   par_in                even-parity bit of the unmasked data
//   sync_in               key-load marker
//   out_valid/out_ready   output handshake for out_data/out_err (FIFO head)
//   out_data, out_err     decoded data and its parity-mismatch flag
//   locked                high while in the locked state
//   err_count             saturating parity-error count
module bm_dag2_demod #(
  parameter int unsigned BITS  = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] sym_in,
  input  logic            par_in,
  input  logic            sync_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_data,
  output logic            out_err,
  output logic            locked,
  output logic [3:0]      err_count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = BITS + 1;

  typedef enum logic [0:0] {StUnsync, StLocked} state_e;

  state_e              state_q, state_d;
  logic [BITS-1:0]     key_q, key_d;
  logic [1:0]          consec_q, consec_d;
  logic [3:0]          err_cnt_q, err_cnt_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [EntW-1:0]     mem_q [DEPTH];

  logic            full;
  logic            accept;
  logic            push;
  logic            pop;
  logic [BITS-1:0] dec_data;
  logic            dec_err;

  // Full blocks writes even when a read happens in the same cycle.
  assign full      = (count_q == CntW'(DEPTH));
  assign in_ready  = ~full & ~reset;
  assign accept    = in_valid & in_ready;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;

  assign dec_data  = sym_in ^ key_q;
  assign dec_err   = (^dec_data) != par_in;

  assign out_data  = mem_q[rd_ptr_q][EntW-1:1];
  assign out_err   = mem_q[rd_ptr_q][0];
  assign locked    = (state_q == StLocked);
  assign err_count = err_cnt_q;

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    consec_d  = consec_q;
    err_cnt_d = err_cnt_q;
    push      = 1'b0;

    if (accept) begin
      if (sync_in) begin
        key_d    = sym_in;
        consec_d = '0;
        state_d  = StLocked;
      end else if (state_q == StLocked) begin
        push  = 1'b1;
        key_d = key_q + BITS'(1);
        if (dec_err) begin
          if (err_cnt_q != 4'd15) begin
            err_cnt_d = err_cnt_q + 4'd1;
          end
          consec_d = consec_q + 2'd1;
          // Third error in a row: entry is still queued, but lock is lost.
          if (consec_q == 2'd2) begin
            state_d = StUnsync;
          end
        end else begin
          consec_d = '0;
        end
      end
      // Data symbols while unsynchronised are silently dropped.
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StUnsync;
      key_q     <= '0;
      consec_q  <= '0;
      err_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      consec_q  <= consec_d;
      err_cnt_q <= err_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible when count_q says so.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {dec_data, dec_err};
    end
  end

endmodule

// File: tb/tb_bm_dag2_demod.sv
module tb_bm_dag2_demod;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] sym_in;
  logic       par_in;
  logic       sync_in;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_data;
  logic       out_err;
  logic       locked;
  logic [3:0] err_count;

  int checks = 0;
  int errors = 0;

  bm_dag2_demod #(.BITS(2), .DEPTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sym_in    (sym_in),
    .par_in    (par_in),
    .sync_in   (sync_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .locked    (locked),
    .err_count (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       sync;
    logic [1:0] sym;
    logic       par;
    logic       push;
    logic [1:0] data;
    logic       err;
    logic       lck;
    logic [3:0] ec;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offer one symbol and wait (bounded) until it is accepted.
  task automatic send(input logic s, input logic [1:0] sym, input logic p);
    int n;
    n = 0;
    @(negedge clock);
    sync_in  = s;
    sym_in   = sym;
    par_in   = p;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 at %0t", $time);
    end
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time got exceeded expected finish");
    $fatal(1);
  end

  logic [1:0] a_sym [5];
  logic       a_par [5];
  logic [1:0] a_exp [5];
  int         exp_ec;

  initial begin
    //            sync sym   par push data  err lck ec
    vecs[0]  = '{1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0};
    vecs[1]  = '{1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 4'd0};
    vecs[2]  = '{1'b0, 2'b11, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 4'd0};
    vecs[3]  = '{1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 4'd0};
    vecs[4]  = '{1'b0, 2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 4'd0};
    vecs[5]  = '{1'b0, 2'b01, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 4'd1};
    vecs[6]  = '{1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 4'd1};
    vecs[7]  = '{1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 4'd2};
    vecs[8]  = '{1'b0, 2'b00, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 4'd3};
    vecs[9]  = '{1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 4'd4};
    vecs[10] = '{1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd4};
    vecs[11] = '{1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 4'd4};
    vecs[12] = '{1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 4'd4};

    a_sym = '{2'b11, 2'b01, 2'b11, 2'b10, 2'b00};
    a_par = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    a_exp = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b11};

    reset     = 1'b1;
    in_valid  = 1'b0;
    sym_in    = '0;
    par_in    = 1'b0;
    sync_in   = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;

    // Back-to-back vectors with out_ready=1: each queued entry is visible
    // for exactly one cycle and is popped as the next symbol is accepted.
    @(negedge clock);
    for (int i = 0; i < 13; i++) begin
      sync_in  = vecs[i].sync;
      sym_in   = vecs[i].sym;
      par_in   = vecs[i].par;
      in_valid = 1'b1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clock);
      @(negedge clock);
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].push));
      if (vecs[i].push) begin
        chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vecs[i].data));
        chk($sformatf("v%0d_out_err", i), 32'(out_err), 32'(vecs[i].err));
      end
      chk($sformatf("v%0d_locked", i), 32'(locked), 32'(vecs[i].lck));
      chk($sformatf("v%0d_err_count", i), 32'(err_count), 32'(vecs[i].ec));
    end
    in_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Fill the FIFO with out_ready=0; key is 11 here.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sync_in  = 1'b0;
      sym_in   = a_sym[i];
      par_in   = a_par[i];
      in_valid = 1'b1;
      chk($sformatf("fill%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clock);
      @(negedge clock);
    end
    sym_in = a_sym[4];
    par_in = a_par[4];
    for (int i = 0; i < 2; i++) begin
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_out_valid", 32'(out_valid), 32'd1);
      chk("hold_out_data", 32'(out_data), 32'd0);
      chk("hold_out_err", 32'(out_err), 32'd0);
      @(posedge clock);
      @(negedge clock);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) chk("full_read_blocks_write", 32'(in_ready), 32'd0);
      if (i == 1) chk("reopen_in_ready", 32'(in_ready), 32'd1);
      if (i == 2) in_valid = 1'b0;
      chk($sformatf("drain%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("drain%0d_data", i), 32'(out_data), 32'(a_exp[i]));
      chk($sformatf("drain%0d_err", i), 32'(out_err), 32'd0);
      @(posedge clock);
      @(negedge clock);
    end
    chk("drain_done", 32'(out_valid), 32'd0);
    chk("fill_err_count", 32'(err_count), 32'd4);

    // Bad-parity symbols interleaved with syncs: count must stick at 15.
    exp_ec = 4;
    for (int j = 0; j < 20; j++) begin
      send(1'b1, 2'b00, 1'b0);
      send(1'b0, 2'b00, 1'b1);
      exp_ec = (exp_ec < 15) ? exp_ec + 1 : 15;
      chk($sformatf("sat%0d_err_count", j), 32'(err_count), 32'(exp_ec));
    end
    chk("sat_locked", 32'(locked), 32'd1);

    // Mid-stream reset with three entries queued and a sync on offer.
    @(negedge clock);
    out_ready = 1'b0;
    send(1'b1, 2'b00, 1'b0);
    send(1'b0, 2'b00, 1'b0);
    send(1'b0, 2'b01, 1'b0);
    send(1'b0, 2'b10, 1'b0);
    @(negedge clock);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_err_count", 32'(err_count), 32'd15);
    reset    = 1'b1;
    sync_in  = 1'b1;
    sym_in   = 2'b11;
    in_valid = 1'b1;
    #1 chk("rst_blocks_in_ready", 32'(in_ready), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_locked", 32'(locked), 32'd0);
    chk("post_rst_err_count", 32'(err_count), 32'd0);
    @(posedge clock);
    @(negedge clock);
    chk("post_rst_valid2", 32'(out_valid), 32'd0);
    chk("post_rst_locked2", 32'(locked), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
